// File: rtl/perm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : perm_gen
//  Purpose  : Random-permutation engine. Holds a table of 2^N_LOG2 index
//             entries and rebuilds it to identity (INIT) or applies a
//             Fisher-Yates shuffle driven by a 16-bit Galois LFSR (SHUFFLE).
//             Serves a registered table read port and raw random words.
//  Revision : 1.0 - initial release
// ============================================================================
module perm_gen #(
  parameter int N_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic              seed_load_i,
  input  logic [15:0]       seed_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic [N_LOG2-1:0] raddr_i,
  output logic [N_LOG2-1:0] rdata_o,
  input  logic              rnd_req_i,
  output logic [15:0]       rnd_o
);

  localparam int          c_depth     = 1 << N_LOG2;
  localparam logic [15:0] c_seed_dflt = 16'hACE1;
  localparam logic [15:0] c_lfsr_taps = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_PICK = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [15:0]         r_lfsr;
  logic [N_LOG2-1:0]   r_i;
  logic [N_LOG2-1:0]   r_perm [c_depth];
  logic [N_LOG2-1:0]   r_rdata;

  logic [15:0]         w_lfsr_next;
  logic [15:0]         w_seed;
  logic [N_LOG2-1:0]   w_mask;
  logic [N_LOG2-1:0]   w_j;
  logic                w_accept;
  logic                w_lfsr_step;
  logic                w_load_seed;
  logic                w_start_pick;
  logic                w_do_init;
  logic                w_do_swap;

  // Galois right-shift LFSR step; zero seeds would lock the LFSR, so swap in the default
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_taps : 16'h0000);
  assign w_seed      = (seed_i == 16'h0000) ? c_seed_dflt : seed_i;

  // Smallest all-ones mask covering i: bit b is set if any bit at or above b of i is set
  generate
    for (genvar b = 0; b < N_LOG2; b++) begin : g_mask
      assign w_mask[b] = |r_i[N_LOG2-1:b];
    end
  endgenerate

  assign w_j      = r_lfsr[N_LOG2-1:0] & w_mask;
  assign w_accept = (w_j <= r_i);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode, datapath strobes and status outputs
  always_comb begin
    w_state_next = r_state;
    w_lfsr_step  = 1'b0;
    w_load_seed  = 1'b0;
    w_start_pick = 1'b0;
    w_do_init    = 1'b0;
    w_do_swap    = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (mode_i) begin
            w_state_next = S_PICK;
            w_start_pick = 1'b1;
            w_load_seed  = seed_load_i;
          end else begin
            w_state_next = S_INIT;
          end
        end else if (rnd_req_i) begin
          w_lfsr_step = 1'b1;
        end
      end
      S_INIT: begin
        busy_o       = 1'b1;
        w_do_init    = 1'b1;
        w_state_next = S_DONE;
      end
      S_PICK: begin
        busy_o      = 1'b1;
        w_lfsr_step = 1'b1;
        w_do_swap   = w_accept;
        if (w_accept && (r_i == N_LOG2'(1))) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done_o       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Table, index counter, LFSR and registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr  <= c_seed_dflt;
      r_i     <= '0;
      r_rdata <= '0;
      for (int k = 0; k < c_depth; k++) begin
        r_perm[k] <= N_LOG2'(k);
      end
    end else begin
      // Read sees pre-update contents, so during PICK it returns pre-swap data
      r_rdata <= r_perm[raddr_i];

      if (w_load_seed) begin
        r_lfsr <= w_seed;
      end else if (w_lfsr_step) begin
        r_lfsr <= w_lfsr_next;
      end

      if (w_start_pick) begin
        r_i <= '1;
      end else if (w_do_swap) begin
        r_i <= r_i - N_LOG2'(1);
      end

      if (w_do_init) begin
        for (int k = 0; k < c_depth; k++) begin
          r_perm[k] <= N_LOG2'(k);
        end
      end else if (w_do_swap) begin
        // When j == i both writes carry the same value, leaving the entry intact
        r_perm[r_i] <= r_perm[w_j];
        r_perm[w_j] <= r_perm[r_i];
      end
    end
  end

  assign rdata_o = r_rdata;
  assign rnd_o   = r_lfsr;

endmodule
`default_nettype wire
